// File: rtl/uart_receiver_if.sv
// UART receive-side bundle: serial line and tick in, byte and status out.
// slave = receiver view, master = line/tick driver and byte consumer view.
interface uart_receiver_if;
  logic       uart_rx;
  logic       sample_tick;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  modport slave (
    input  uart_rx,
    input  sample_tick,
    output data,
    output data_valid,
    output frame_error,
    output busy
  );

  modport master (
    output uart_rx,
    output sample_tick,
    input  data,
    input  data_valid,
    input  frame_error,
    input  busy
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, oversampled on sample_tick, mid-bit sampling.
// Ports: clk, reset (async high), bus (uart_receiver_if.slave).
module uart_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  uart_receiver_if.slave bus
);

  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int SHR = 8 - DATA_BITS;

  localparam logic [TW-1:0] T_MID =
    TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END =
    TW'(OVERSAMPLE - 1);
  localparam logic [3:0] B_LAST =
    4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic [TW-1:0] tick_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic [7:0]    data_q;
  logic          dv_q;
  logic          fe_q;
  logic          busy_q;

  assign bus.data        = data_q;
  assign bus.data_valid  = dv_q;
  assign bus.frame_error = fe_q;
  assign bus.busy        = busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      data_q   <= '0;
      dv_q     <= 1'b0;
      fe_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rx_meta <= bus.uart_rx;
      rx_s    <= rx_meta;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      if (bus.sample_tick) begin
        unique case (state)
          IDLE: begin
            if (!rx_s) begin
              state    <= START;
              busy_q   <= 1'b1;
              tick_cnt <= '0;
            end
          end
          START: begin
            if (tick_cnt == T_MID) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              if (!rx_s) begin
                state <= DATA;
              end else begin
                state  <= IDLE;
                busy_q <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (tick_cnt == T_END) begin
              // line is LSB first: shift in at MSB
              shift    <= {rx_s, shift[7:1]};
              tick_cnt <= '0;
              bit_cnt  <= bit_cnt + 4'd1;
              if (bit_cnt == B_LAST)
                state <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          STOP: begin
            if (tick_cnt == T_END) begin
              tick_cnt <= '0;
              if (rx_s) begin
                data_q <= shift >> SHR;
                dv_q   <= 1'b1;
                state  <= IDLE;
                busy_q <= 1'b0;
              end else begin
                fe_q  <= 1'b1;
                state <= WAIT_HIGH;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          WAIT_HIGH: begin
            // a held-low line must not look like a start bit
            if (rx_s) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: 8N1 frames, tick every 4th clk.
// Checks pulses, data, busy, glitch, framing error and async reset.
module tb_uart_receiver;

  localparam int BITCLK = 64;

  logic clk;
  logic reset;
  logic [1:0] div;

  int tests;
  int failed;

  int   valid_cnt;
  int   fe_cnt;
  logic both_high;
  logic wide_pulse;
  logic prev_dv;
  logic prev_fe;
  logic [7:0] rxq[$];

  uart_receiver_if u_if ();

  uart_receiver #(
    .DATA_BITS (8),
    .OVERSAMPLE(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) div <= div + 2'd1;
  assign u_if.sample_tick = (div == 2'd3);

  initial begin
    valid_cnt  = 0;
    fe_cnt     = 0;
    both_high  = 1'b0;
    wide_pulse = 1'b0;
    prev_dv    = 1'b0;
    prev_fe    = 1'b0;
  end

  always @(negedge clk) begin
    if (u_if.data_valid) begin
      valid_cnt = valid_cnt + 1;
      rxq.push_back(u_if.data);
    end
    if (u_if.frame_error)
      fe_cnt = fe_cnt + 1;
    if (u_if.data_valid && u_if.frame_error)
      both_high = 1'b1;
    if ((u_if.data_valid && prev_dv) ||
        (u_if.frame_error && prev_fe))
      wide_pulse = 1'b1;
    prev_dv = u_if.data_valid;
    prev_fe = u_if.frame_error;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    u_if.uart_rx = v;
    wait_clks(BITCLK);
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++)
      send_bit(b[i]);
    send_bit(stop);
  endtask

  initial begin
    tests        = 0;
    failed       = 0;
    div          = 2'd0;
    u_if.uart_rx = 1'b1;
    reset        = 1'b1;
    wait_clks(5);
    check("rst_data", 32'(u_if.data), 32'h00);
    check("rst_busy", 32'(u_if.busy), 32'h0);
    check("rst_dv", 32'(u_if.data_valid), 32'h0);
    reset = 1'b0;

    // 1: idle line
    wait_clks(200);
    check("idle_busy", 32'(u_if.busy), 32'h0);
    check("idle_valid", valid_cnt, 0);
    check("idle_fe", fe_cnt, 0);
    check("idle_data", 32'(u_if.data), 32'h00);

    // 2: single byte
    send_frame(8'h41, 1'b1);
    wait_clks(BITCLK);
    check("b41_cnt", valid_cnt, 1);
    check("b41_data", 32'(u_if.data), 32'h41);
    check("b41_fe", fe_cnt, 0);
    check("b41_busy", 32'(u_if.busy), 32'h0);

    // 3: back-to-back
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'hA5, 1'b1);
    wait_clks(BITCLK);
    check("b2b_cnt", valid_cnt, 4);
    if (rxq.size() == 4) begin
      check("b2b_0", 32'(rxq[1]), 32'h00);
      check("b2b_1", 32'(rxq[2]), 32'hFF);
      check("b2b_2", 32'(rxq[3]), 32'hA5);
    end else begin
      check("b2b_qsize", rxq.size(), 4);
    end
    check("b2b_data", 32'(u_if.data), 32'hA5);

    // 4: glitch of 3 ticks
    u_if.uart_rx = 1'b0;
    wait_clks(12);
    check("gl_busy_hi", 32'(u_if.busy), 32'h1);
    u_if.uart_rx = 1'b1;
    wait_clks(2 * BITCLK);
    check("gl_busy_lo", 32'(u_if.busy), 32'h0);
    check("gl_cnt", valid_cnt, 4);
    check("gl_fe", fe_cnt, 0);
    check("gl_data", 32'(u_if.data), 32'hA5);

    // 5: bad stop bit then break
    send_frame(8'h3C, 1'b0);
    wait_clks(5 * BITCLK);
    check("fe_cnt", fe_cnt, 1);
    check("fe_busy", 32'(u_if.busy), 32'h1);
    check("fe_data", 32'(u_if.data), 32'hA5);
    check("fe_valid", valid_cnt, 4);
    u_if.uart_rx = 1'b1;
    wait_clks(BITCLK);
    check("fe_busy_lo", 32'(u_if.busy), 32'h0);
    send_frame(8'h55, 1'b1);
    wait_clks(BITCLK);
    check("b55_data", 32'(u_if.data), 32'h55);
    check("b55_cnt", valid_cnt, 5);
    check("b55_fe", fe_cnt, 1);

    // 6: async reset during bit 4 of 0x81
    send_bit(1'b0);
    for (int i = 0; i < 4; i++)
      send_bit(i == 0);
    u_if.uart_rx = 1'b0;
    wait_clks(BITCLK / 2);
    check("mr_busy_pre", 32'(u_if.busy), 32'h1);
    reset = 1'b1;
    #1;
    check("mr_data", 32'(u_if.data), 32'h00);
    check("mr_busy", 32'(u_if.busy), 32'h0);
    check("mr_dv", 32'(u_if.data_valid), 32'h0);
    check("mr_fe", 32'(u_if.frame_error), 32'h0);
    u_if.uart_rx = 1'b1;
    wait_clks(10);
    reset = 1'b0;
    wait_clks(2 * BITCLK);
    check("mr_cnt", valid_cnt, 5);
    check("mr_fecnt", fe_cnt, 1);
    send_frame(8'h81, 1'b1);
    wait_clks(BITCLK);
    check("b81_data", 32'(u_if.data), 32'h81);
    check("b81_cnt", valid_cnt, 6);

    check("both_high", 32'(both_high), 32'h0);
    check("wide_pulse", 32'(wide_pulse), 32'h0);

    $display("[TB] %0d tests run, %0d failed",
             tests, failed);
    $finish;
  end

endmodule
